// File: rtl/wave_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen_pkg
//  Description : Shared definitions for the wave_gen block. Holds the
//                generator state encoding, the minimum legal period and the
//                configuration loaded at reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_gen_pkg;

    // Generator states; explicit 2-bit encoding shared by all files.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Shortest period that still produces a visible low/high transition.
    localparam int MIN_PERIOD = 2;

    // Active configuration after reset: a 50% square wave of period 2.
    localparam int RST_PERIOD = 2;
    localparam int RST_HIGH   = 1;

endpackage : wave_gen_pkg
`default_nettype wire

// File: rtl/wave_gen_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen_shadow
//  Description : Configuration shadow register for wave_gen. Accepts a new
//                (period, high) pair over a valid/ready handshake, clamps it
//                to a legal range and holds it until the generator applies it.
//  Ports       : clock1, reset        - clock and synchronous active-high reset
//                load_valid/_ready    - config handshake
//                load_period/_high    - requested period P and high time H
//                apply                - strobe from the generator: the pending
//                                       pair has just become active
//                pending_vld          - a sanitised pair is held
//                pend_p, pend_h       - the held pair
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_gen_shadow
    import wave_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock1,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_period,
    input  logic [CNT_W-1:0] load_high,
    input  logic             apply,
    output logic             load_ready,
    output logic             pending_vld,
    output logic [CNT_W-1:0] pend_p,
    output logic [CNT_W-1:0] pend_h
);

    logic             r_pend_vld;
    logic [CNT_W-1:0] r_pend_p;
    logic [CNT_W-1:0] r_pend_h;

    logic             w_accept;
    logic [CNT_W-1:0] w_p_san;
    logic [CNT_W-1:0] w_h_san;

    // Only one pair can wait at a time; ready reflects an empty slot.
    assign load_ready = ~r_pend_vld;
    assign w_accept   = load_valid & load_ready;

    // P is raised to the minimum first, so H is clamped against the final P.
    always_comb begin
        w_p_san = load_period;
        if (load_period < CNT_W'(MIN_PERIOD)) begin
            w_p_san = CNT_W'(MIN_PERIOD);
        end
        w_h_san = load_high;
        if (load_high > w_p_san) begin
            w_h_san = w_p_san;
        end
    end

    // apply is only raised while a pair is pending, and accept needs an empty
    // slot, so the two never coincide.
    always_ff @(posedge clock1) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
            r_pend_p   <= CNT_W'(RST_PERIOD);
            r_pend_h   <= CNT_W'(RST_HIGH);
        end else if (apply) begin
            r_pend_vld <= 1'b0;
        end else if (w_accept) begin
            r_pend_vld <= 1'b1;
            r_pend_p   <= w_p_san;
            r_pend_h   <= w_h_san;
        end
    end

    assign pending_vld = r_pend_vld;
    assign pend_p      = r_pend_p;
    assign pend_h      = r_pend_h;

endmodule : wave_gen_shadow
`default_nettype wire

// File: rtl/wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen
//  Description : Programmable square/PWM wave generator. A counter walks each
//                P-cycle period and the output is high for the first H cycles.
//                New (P, H) pairs are swapped in only on period boundaries, so
//                the output never glitches.
//  Ports       : clock1, reset   - clock and synchronous active-high reset
//                enable          - level-sensitive run request
//                load_valid/_ready, load_period, load_high - config handshake
//                wave_out        - registered wave
//                period_tick     - high in the last cycle of each period
//                busy            - generator is in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock1,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_period,
    input  logic [CNT_W-1:0] load_high,
    output logic             load_ready,
    output logic             wave_out,
    output logic             period_tick,
    output logic             busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_h;
    logic             r_wave;
    logic             r_tick;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_p_nxt;
    logic [CNT_W-1:0] w_h_nxt;
    logic             w_wave_nxt;
    logic             w_tick_nxt;
    logic             w_apply;
    logic             w_wrap;

    logic             w_pend_vld;
    logic [CNT_W-1:0] w_pend_p;
    logic [CNT_W-1:0] w_pend_h;

    wave_gen_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clock1      (clock1),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_period (load_period),
        .load_high   (load_high),
        .apply       (w_apply),
        .load_ready  (load_ready),
        .pending_vld (w_pend_vld),
        .pend_p      (w_pend_p),
        .pend_h      (w_pend_h)
    );

    assign w_wrap = (r_cnt == r_p - CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_apply     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_apply   = w_pend_vld;
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    w_apply   = w_pend_vld;
                    if (!enable) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (!enable) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Finish the started period regardless of enable.
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_apply     = w_pend_vld;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // The outputs are evaluated against the config of the period that the
        // next count belongs to, which is the pending pair when it is applied.
        w_p_nxt = w_apply ? w_pend_p : r_p;
        w_h_nxt = w_apply ? w_pend_h : r_h;

        w_wave_nxt = (w_state_nxt != IDLE) && (w_cnt_nxt < w_h_nxt);
        w_tick_nxt = (w_state_nxt != IDLE) && (w_cnt_nxt == w_p_nxt - CNT_W'(1));
    end

    always_ff @(posedge clock1) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_p     <= CNT_W'(RST_PERIOD);
            r_h     <= CNT_W'(RST_HIGH);
            r_wave  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p     <= w_p_nxt;
            r_h     <= w_h_nxt;
            r_wave  <= w_wave_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign wave_out    = r_wave;
    assign period_tick = r_tick;
    assign busy        = (r_state == RUN);

endmodule : wave_gen
`default_nettype wire

// File: tb/tb_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_gen
//  Description : Self-checking bench for wave_gen. Each driven cycle pushes
//                the expected {wave_out, period_tick, busy, load_ready} for
//                the following edge; the value is popped and compared after
//                that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_gen;

    localparam int CNT_W = 8;

    logic             clock1 = 1'b0;
    logic             reset;
    logic             enable;
    logic             load_valid;
    logic [CNT_W-1:0] load_period;
    logic [CNT_W-1:0] load_high;
    logic             load_ready;
    logic             wave_out;
    logic             period_tick;
    logic             busy;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock1 = ~clock1;

    wave_gen #(
        .CNT_W (CNT_W)
    ) dut (
        .clock1      (clock1),
        .reset       (reset),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_period (load_period),
        .load_high   (load_high),
        .load_ready  (load_ready),
        .wave_out    (wave_out),
        .period_tick (period_tick),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (wave,tick,busy,ready) at %0t",
                     tag, got[3:0], exp[3:0], $time);
        end
    endtask

    // {wave, tick} for cycle i of a period with period p and high time h.
    function automatic logic [1:0] pat(input int p, input int h, input int i);
        return {logic'(i < h), logic'(i == p - 1)};
    endfunction

    // Drive one cycle of inputs, record what must be visible after the edge,
    // then compare it after the edge.
    task automatic cyc(input logic en, input logic lv, input int lp, input int lh,
                       input logic [3:0] exp, input string tag);
        exp_t e;
        int   p_v;
        int   h_v;
        p_v         = lp;
        h_v         = lh;
        enable      = en;
        load_valid  = lv;
        load_period = p_v[CNT_W-1:0];
        load_high   = h_v[CNT_W-1:0];
        sb.push_back('{tag: tag, exp: exp});
        @(posedge clock1);
        #1;
        e = sb.pop_front();
        check_eq(e.tag, {28'd0, wave_out, period_tick, busy, load_ready}, {28'd0, e.exp});
    endtask

    // Run n cycles in RUN from count 0 with no load offered.
    task automatic run_cfg(input int p, input int h, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 0, 0, {pat(p, h, i % p), 2'b11}, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        load_valid  = 1'b0;
        load_period = '0;
        load_high   = '0;

        // Reset values.
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "reset0");
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "reset1");
        reset = 1'b0;

        // Defaults P=2/H=1: 1,0,1,0 with a tick every second cycle.
        run_cfg(2, 1, 6, "dflt");

        // Enable falls in the wrap cycle: straight to IDLE.
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "dflt_stop");

        // Load P=5/H=2 in IDLE: ready low for one cycle.
        cyc(1'b0, 1'b1, 5, 2, 4'b0000, "ld52_acc");
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "ld52_apply");
        run_cfg(5, 2, 10, "p5h2");

        // Load P=4/H=3 at cnt=1; current period completes first.
        run_cfg(5, 2, 2, "p5h2_b");
        cyc(1'b1, 1'b1, 4, 3, {pat(5, 2, 2), 2'b10}, "ld43_c2");
        cyc(1'b1, 1'b0, 0, 0, {pat(5, 2, 3), 2'b10}, "ld43_c3");
        cyc(1'b1, 1'b0, 0, 0, {pat(5, 2, 4), 2'b10}, "ld43_c4");
        run_cfg(4, 3, 8, "p4h3");

        // Sanitise: P=0, H=9 becomes P=2, H=2 (constant high).
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "san1_idle");
        cyc(1'b0, 1'b1, 0, 9, 4'b0000, "san1_acc");
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "san1_apply");
        run_cfg(2, 2, 6, "san_p2h2");

        // Sanitise: P=6, H=0 gives constant low, tick every 6 cycles.
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "san2_idle");
        cyc(1'b0, 1'b1, 6, 0, 4'b0000, "san2_acc");
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "san2_apply");
        run_cfg(6, 0, 12, "san_p6h0");

        // P=5/H=2, drop enable at cnt=2: period finishes in STOP.
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "stp_idle");
        cyc(1'b0, 1'b1, 5, 2, 4'b0000, "stp_acc");
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "stp_apply");
        run_cfg(5, 2, 3, "stp_run");
        cyc(1'b0, 1'b0, 0, 0, {pat(5, 2, 3), 2'b01}, "stop_c3");
        cyc(1'b1, 1'b0, 0, 0, {pat(5, 2, 4), 2'b01}, "stop_ign_en");
        cyc(1'b1, 1'b0, 0, 0, 4'b0001, "stop_to_idle");
        // Restart, then drop enable at cnt=4.
        run_cfg(5, 2, 5, "restart");
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "drop_wrap");

        // Reset mid-period with a config pending.
        run_cfg(5, 2, 2, "pre_rst");
        cyc(1'b1, 1'b1, 4, 3, {pat(5, 2, 2), 2'b10}, "pend_rst");
        reset = 1'b1;
        cyc(1'b1, 1'b0, 0, 0, 4'b0001, "rst_mid");
        reset = 1'b0;
        cyc(1'b0, 1'b0, 0, 0, 4'b0001, "post_rst");
        run_cfg(2, 1, 4, "rst_dflt");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wave_gen
`default_nettype wire
